// File: rtl/f_min_max.sv
// Binary32 min/max and less-than/less-or-equal compare unit (RISC-V FMAX/FMIN/FLT/FLE).
// Combinational compare feeding one output register; rd and fflag_nv hold while idle.
module f_min_max (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [1:0]  func_type,
   output logic [31:0] rd,
   output logic        out_valid,
   output logic        fflag_nv
);

   typedef enum logic [1:0] {
      FMAX  = 2'b00,
      FMIN  = 2'b01,
      F_LT  = 2'b10,
      F_LEQ = 2'b11
   } func_e;

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

   func_e       func;
   logic        a_nan, b_nan, a_snan, b_snan, any_nan;
   logic        a_sign, b_sign;
   logic [30:0] a_mag, b_mag;
   logic        a_lt_ord, both_zero, cmp_lt, cmp_le;
   logic [31:0] res_rd;
   logic        res_nv;

   always_comb begin
      func    = func_e'(func_type);
      a_sign  = rs1[31];
      b_sign  = rs2[31];
      a_mag   = rs1[30:0];
      b_mag   = rs2[30:0];
      a_nan   = (&rs1[30:23]) && (|rs1[22:0]);
      b_nan   = (&rs2[30:23]) && (|rs2[22:0]);
      a_snan  = a_nan && !rs1[22];
      b_snan  = b_nan && !rs2[22];
      any_nan = a_nan || b_nan;

      // Total order on sign-magnitude with -0 < +0; compares then treat the zeros as equal.
      if (a_sign != b_sign)
         a_lt_ord = a_sign;
      else if (!a_sign)
         a_lt_ord = a_mag < b_mag;
      else
         a_lt_ord = a_mag > b_mag;

      both_zero = (a_mag == '0) && (b_mag == '0);
      cmp_lt    = a_lt_ord && !both_zero;
      cmp_le    = cmp_lt || both_zero || (rs1 == rs2);
   end

   always_comb begin
      res_rd = '0;
      res_nv = 1'b0;
      unique case (func)
         FMAX, FMIN: begin
            res_nv = a_snan || b_snan;
            if (a_nan && b_nan)
               res_rd = CANON_NAN;
            else if (a_nan)
               res_rd = rs2;
            else if (b_nan)
               res_rd = rs1;
            else if (func == FMAX)
               res_rd = a_lt_ord ? rs2 : rs1;
            else
               res_rd = a_lt_ord ? rs1 : rs2;
         end
         F_LT: begin
            res_nv    = any_nan;
            res_rd[0] = !any_nan && cmp_lt;
         end
         F_LEQ: begin
            res_nv    = any_nan;
            res_rd[0] = !any_nan && cmp_le;
         end
         default: begin
            res_rd = '0;
            res_nv = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd        <= '0;
         out_valid <= 1'b0;
         fflag_nv  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            rd       <= res_rd;
            fflag_nv <= res_nv;
         end
      end
   end

endmodule

// File: tb/tb_f_min_max.sv
// Directed vector bench for f_min_max: table of hand-computed results applied back to back,
// plus reset-vs-valid and idle-hold sequences.
module tb_f_min_max;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [1:0]  func_type;
   logic [31:0] rd;
   logic        out_valid;
   logic        fflag_nv;

   int n_checks = 0;
   int n_fail   = 0;

   f_min_max dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .rs1       (rs1),
      .rs2       (rs2),
      .func_type (func_type),
      .rd        (rd),
      .out_valid (out_valid),
      .fflag_nv  (fflag_nv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  func;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_rd;
      logic        exp_nv;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input logic nv);
      vec_t v;
      v.func = f; v.a = a; v.b = b; v.exp_rd = e; v.exp_nv = nv;
      vecs.push_back(v);
   endtask

   initial begin
      // max/min of positives, mixed signs, signed zeros
      add(2'b00, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0);
      add(2'b01, 32'h3F800000, 32'h40000000, 32'h3F800000, 1'b0);
      add(2'b00, 32'hBF800000, 32'h40000000, 32'h40000000, 1'b0);
      add(2'b01, 32'hBF800000, 32'h40000000, 32'hBF800000, 1'b0);
      add(2'b01, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0);
      add(2'b00, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
      add(2'b00, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
      // NaN handling
      add(2'b00, 32'h7FC00000, 32'h40000000, 32'h40000000, 1'b0);
      add(2'b01, 32'h7FC00000, 32'h40000000, 32'h40000000, 1'b0);
      add(2'b00, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 1'b0);
      add(2'b01, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 1'b0);
      add(2'b00, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0);
      add(2'b00, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1);
      add(2'b01, 32'hFFC00001, 32'h7F800001, 32'h7FC00000, 1'b1);
      add(2'b00, 32'h7FC00000, 32'h80000000, 32'h80000000, 1'b0);
      // compares
      add(2'b10, 32'h3F800000, 32'h40000000, 32'h00000001, 1'b0);
      add(2'b11, 32'h3F800000, 32'h40000000, 32'h00000001, 1'b0);
      add(2'b10, 32'h40000000, 32'h3F800000, 32'h00000000, 1'b0);
      add(2'b11, 32'h40000000, 32'h3F800000, 32'h00000000, 1'b0);
      add(2'b10, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0);
      add(2'b11, 32'h3F800000, 32'h3F800000, 32'h00000001, 1'b0);
      add(2'b11, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0);
      add(2'b10, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
      add(2'b11, 32'h00000000, 32'h80000000, 32'h00000001, 1'b0);
      add(2'b10, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1);
      add(2'b11, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1);
      add(2'b11, 32'h3F800000, 32'h7F800001, 32'h00000000, 1'b1);
      add(2'b10, 32'hBF800000, 32'hC0000000, 32'h00000000, 1'b0);
      add(2'b10, 32'hC0000000, 32'hBF800000, 32'h00000001, 1'b0);
      // negatives, infinities, denormals
      add(2'b00, 32'hC0000000, 32'hBF800000, 32'hBF800000, 1'b0);
      add(2'b01, 32'hFF800000, 32'h00000001, 32'hFF800000, 1'b0);
      add(2'b00, 32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 1'b0);
      add(2'b01, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0);

      rst_n = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; func_type = '0;

      // reset wins over a simultaneous valid operation
      @(negedge clk);
      in_valid = 1'b1; rs1 = 32'h3F800000; rs2 = 32'h40000000; func_type = 2'b00;
      @(posedge clk); #1;
      check("reset_rd", rd, 32'h0);
      check("reset_valid", {31'b0, out_valid}, 32'h0);
      check("reset_nv", {31'b0, fflag_nv}, 32'h0);

      // back-to-back table; each result checked one edge after issue
      @(negedge clk);
      rst_n = 1'b1;
      for (int unsigned i = 0; i < vecs.size(); i++) begin
         rs1 = vecs[i].a; rs2 = vecs[i].b; func_type = vecs[i].func; in_valid = 1'b1;
         @(posedge clk); #1;
         check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
         check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_nv", i), {31'b0, fflag_nv}, {31'b0, vecs[i].exp_nv});
         @(negedge clk);
      end

      // idle cycles: out_valid drops, rd and nv hold (last vector: 00000001, nv 0)
      in_valid = 1'b0; rs1 = 32'h7F800001; rs2 = 32'h12345678; func_type = 2'b11;
      @(posedge clk); #1;
      check("idle_valid", {31'b0, out_valid}, 32'h0);
      check("idle_rd_hold", rd, 32'h00000001);
      check("idle_nv_hold", {31'b0, fflag_nv}, 32'h0);

      // flag set, then hold across idle
      @(negedge clk);
      in_valid = 1'b1; rs1 = 32'h7F800001; rs2 = 32'h3F800000; func_type = 2'b01;
      @(posedge clk); #1;
      check("snan_min_rd", rd, 32'h3F800000);
      check("snan_min_nv", {31'b0, fflag_nv}, 32'h1);
      @(negedge clk);
      in_valid = 1'b0; rs1 = 32'h00000000; rs2 = 32'h00000000; func_type = 2'b00;
      @(posedge clk); #1;
      check("hold2_valid", {31'b0, out_valid}, 32'h0);
      check("hold2_rd", rd, 32'h3F800000);
      check("hold2_nv", {31'b0, fflag_nv}, 32'h1);
      @(posedge clk); #1;
      check("hold3_rd", rd, 32'h3F800000);

      // reset clears held state even with a valid op presented
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b1; rs1 = 32'h40000000; rs2 = 32'h3F800000; func_type = 2'b00;
      @(posedge clk); #1;
      check("rst2_rd", rd, 32'h0);
      check("rst2_valid", {31'b0, out_valid}, 32'h0);
      check("rst2_nv", {31'b0, fflag_nv}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
